// File: rtl/mem_responder_pkg.sv
// Shared types for the memory responder: access-size encodings, FSM states
// and the wait-state counter width.
package mem_pkg;

    localparam logic [1:0] SZ_WORD  = 2'b00;
    localparam logic [1:0] SZ_BYTE  = 2'b01;
    localparam logic [1:0] SZ_HALF  = 2'b10;
    localparam logic [1:0] SZ_WORD2 = 2'b11;

    localparam int WAIT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        RESP = 2'b10
    } state_t;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between the core (master) and the memory responder (slave).
interface mem_responder_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int CELL_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [1:0]            req_size;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [CELL_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [CELL_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/mem_responder_lane_align.sv
// Byte-lane steering for sub-word accesses: merges store data into the current
// word, extracts zero-extended load data and flags misaligned addresses.
module lane_align
    import mem_pkg::*;
#(
    parameter int CELL_WIDTH = 32
) (
    input  logic [1:0]            size,
    input  logic [1:0]            lane,
    input  logic [CELL_WIDTH-1:0] cur_word,
    input  logic [CELL_WIDTH-1:0] wdata,
    output logic [CELL_WIDTH-1:0] wr_word,
    output logic [3:0]            byte_en,
    output logic [CELL_WIDTH-1:0] rd_data,
    output logic                  misalign
);
    logic [CELL_WIDTH-1:0] wdata_rep;

    always_comb begin
        byte_en   = 4'b0000;
        rd_data   = '0;
        misalign  = 1'b0;
        wdata_rep = wdata;
        case (size)
            SZ_BYTE: begin
                byte_en   = 4'b0001 << lane;
                rd_data   = CELL_WIDTH'(cur_word[{lane, 3'b000} +: 8]);
                wdata_rep = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                misalign  = lane[0];
                byte_en   = lane[1] ? 4'b1100 : 4'b0011;
                rd_data   = CELL_WIDTH'(cur_word[{lane[1], 4'b0000} +: 16]);
                wdata_rep = {2{wdata[15:0]}};
            end
            default: begin
                misalign = |lane;
                byte_en  = 4'b1111;
                rd_data  = cur_word;
            end
        endcase
        if (misalign) begin
            byte_en = 4'b0000;
        end
    end

    // Replicated store data lets each enabled lane pick its byte straight across.
    always_comb begin
        wr_word = cur_word;
        for (int b = 0; b < 4; b++) begin
            if (byte_en[b]) begin
                wr_word[8*b +: 8] = wdata_rep[8*b +: 8];
            end
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder with programmable wait states: one outstanding request,
// byte/half/word sizing, error response for misaligned or out-of-range accesses.
module mem_responder
    import mem_pkg::*;
#(
    parameter int CELL_WIDTH  = 32,
    parameter int MEM_DEPTH   = 1024,
    parameter int ADDR_WIDTH  = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic           CLK,
    input  logic           RST,
    mem_responder_if.slave bus
);
    localparam int MW = $clog2(MEM_DEPTH);

    state_t                state;
    logic [WAIT_W-1:0]     wait_cnt;
    logic                  cap_we;
    logic [1:0]            cap_size;
    logic [ADDR_WIDTH-1:0] cap_addr;
    logic [CELL_WIDTH-1:0] cap_wdata;

    logic                  req_ready_q;
    logic                  rsp_valid_q;
    logic                  rsp_err_q;
    logic [CELL_WIDTH-1:0] rsp_rdata_q;

    logic [CELL_WIDTH-1:0] mem [MEM_DEPTH];

    logic [ADDR_WIDTH-1:0] word_idx;
    logic [MW-1:0]         mem_addr;
    logic                  out_of_range;
    logic                  misalign;
    logic                  access_err;
    logic                  access_now;
    logic                  mem_we;
    logic [CELL_WIDTH-1:0] cur_word;
    logic [CELL_WIDTH-1:0] wr_word;
    logic [CELL_WIDTH-1:0] rd_data;
    logic [3:0]            byte_en;

    assign word_idx     = cap_addr >> 2;
    assign mem_addr     = word_idx[MW-1:0];
    assign out_of_range = word_idx >= ADDR_WIDTH'(MEM_DEPTH);
    assign cur_word     = mem[mem_addr];
    assign access_err   = out_of_range | misalign;
    assign access_now   = (state == BUSY) && (wait_cnt == '0);
    assign mem_we       = access_now && cap_we && !access_err && (|byte_en);

    lane_align #(
        .CELL_WIDTH (CELL_WIDTH)
    ) u_lane_align (
        .size     (cap_size),
        .lane     (cap_addr[1:0]),
        .cur_word (cur_word),
        .wdata    (cap_wdata),
        .wr_word  (wr_word),
        .byte_en  (byte_en),
        .rd_data  (rd_data),
        .misalign (misalign)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            cap_we      <= 1'b0;
            cap_size    <= SZ_WORD;
            cap_addr    <= '0;
            cap_wdata   <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        cap_we      <= bus.req_we;
                        cap_size    <= bus.req_size;
                        cap_addr    <= bus.req_addr;
                        cap_wdata   <= bus.req_wdata;
                        wait_cnt    <= WAIT_W'(WAIT_CYCLES);
                        req_ready_q <= 1'b0;
                        state       <= BUSY;
                    end
                end
                BUSY: begin
                    if (wait_cnt == '0) begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= access_err;
                        rsp_rdata_q <= (cap_we || access_err) ? '0 : rd_data;
                        state       <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b0;
                        req_ready_q <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Array has no reset; a reset during BUSY forces IDLE so no write can follow.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[mem_addr] <= wr_word;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule
